// File: rtl/int_ack_sequencer_if.sv
// int_ack_sequencer_if: interrupt-control, INTA and memory-transfer signals of the acknowledge sequencer
interface int_ack_sequencer_if;
    logic        TINT;
    logic        InstrEnd;
    logic [1:0]  IM;
    logic [7:0]  I_Reg;
    logic [15:0] PC;
    logic [15:0] SP;
    logic [7:0]  DataIn;
    logic        BusDone;
    logic [7:0]  BusRData;
    logic        Busy;
    logic        IntAck;
    logic        Reset_TINT;
    logic        ClearIFF;
    logic        BusReq;
    logic        BusWrite;
    logic [15:0] BusAddr;
    logic [7:0]  BusWData;
    logic        SP_Load;
    logic [15:0] SP_New;
    logic        PC_Load;
    logic [15:0] PC_New;

    modport master (
        input  TINT, InstrEnd, IM, I_Reg, PC, SP, DataIn, BusDone, BusRData,
        output Busy, IntAck, Reset_TINT, ClearIFF, BusReq, BusWrite, BusAddr, BusWData,
               SP_Load, SP_New, PC_Load, PC_New
    );

    modport slave (
        output TINT, InstrEnd, IM, I_Reg, PC, SP, DataIn, BusDone, BusRData,
        input  Busy, IntAck, Reset_TINT, ClearIFF, BusReq, BusWrite, BusAddr, BusWData,
               SP_Load, SP_New, PC_Load, PC_New
    );
endinterface

// File: rtl/int_ack_sequencer.sv
// int_ack_sequencer: maskable-interrupt response - INTA, PC push, vector resolution and PC load
module int_ack_sequencer #(
    parameter logic [15:0] IM1_VECTOR = 16'h0038,
    parameter int unsigned ACK_WAITS  = 2
) (
    input logic                 Clk,
    input logic                 Reset,
    int_ack_sequencer_if.master ifc_io
);
    typedef enum logic [2:0] {IDLE, ACK, PUSH_H, PUSH_L, RD_L, RD_H, LOAD} state_t;

    state_t      state_q;
    logic [1:0]  im_q;
    logic [15:0] pc_q, sp_q;
    logic [7:0]  i_q, vec_q, cnt_q;
    logic        busy_q, int_ack_q, reset_tint_q, clear_iff_q;
    logic        bus_req_q, bus_write_q, sp_load_q, pc_load_q;
    logic [15:0] bus_addr_q, sp_new_q, pc_new_q;
    logic [7:0]  bus_wdata_q;
    logic [15:0] xfer_addr_d, vec_pc_d;
    logic [7:0]  xfer_wdata_d;

    assign ifc_io.Busy       = busy_q;
    assign ifc_io.IntAck     = int_ack_q;
    assign ifc_io.Reset_TINT = reset_tint_q;
    assign ifc_io.ClearIFF   = clear_iff_q;
    assign ifc_io.BusReq     = bus_req_q;
    assign ifc_io.BusWrite   = bus_write_q;
    assign ifc_io.BusAddr    = bus_addr_q;
    assign ifc_io.BusWData   = bus_wdata_q;
    assign ifc_io.SP_Load    = sp_load_q;
    assign ifc_io.SP_New     = sp_new_q;
    assign ifc_io.PC_Load    = pc_load_q;
    assign ifc_io.PC_New     = pc_new_q;

    // Transfer the current state issues once the bus is idle, and the non-table PC target
    always_comb begin
        xfer_addr_d  = state_q == PUSH_H ? sp_q - 16'd1 :
                       state_q == PUSH_L ? sp_q - 16'd2 : {i_q, vec_q[7:1], state_q == RD_H};
        xfer_wdata_d = state_q == PUSH_H ? pc_q[15:8] : state_q == PUSH_L ? pc_q[7:0] : 8'h00;
        vec_pc_d     = im_q == 2'd0 ? {10'b0, vec_q[5:3], 3'b0} : IM1_VECTOR;
    end

    // Sequencer FSM; transfer states raise BusReq on their first cycle so each transfer follows an idle bus cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            im_q         <= 2'd0;
            pc_q         <= 16'h0000;
            sp_q         <= 16'h0000;
            i_q          <= 8'h00;
            vec_q        <= 8'h00;
            cnt_q        <= 8'h00;
            busy_q       <= 1'b0;
            int_ack_q    <= 1'b0;
            reset_tint_q <= 1'b0;
            clear_iff_q  <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_write_q  <= 1'b0;
            bus_addr_q   <= 16'h0000;
            bus_wdata_q  <= 8'h00;
            sp_load_q    <= 1'b0;
            sp_new_q     <= 16'h0000;
            pc_load_q    <= 1'b0;
            pc_new_q     <= 16'h0000;
        end else begin
            reset_tint_q <= 1'b0;
            clear_iff_q  <= 1'b0;
            sp_load_q    <= 1'b0;
            pc_load_q    <= 1'b0;
            case (state_q)
                IDLE: if (ifc_io.TINT && ifc_io.InstrEnd) begin
                    state_q      <= ACK;
                    im_q         <= ifc_io.IM;
                    pc_q         <= ifc_io.PC;
                    sp_q         <= ifc_io.SP;
                    i_q          <= ifc_io.I_Reg;
                    cnt_q        <= 8'h00;
                    busy_q       <= 1'b1;
                    int_ack_q    <= 1'b1;
                    reset_tint_q <= 1'b1;
                    clear_iff_q  <= 1'b1;
                end
                ACK: if (cnt_q == 8'(ACK_WAITS)) begin
                    vec_q     <= ifc_io.DataIn;
                    int_ack_q <= 1'b0;
                    state_q   <= PUSH_H;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
                LOAD: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: if (!bus_req_q) begin
                    bus_req_q   <= 1'b1;
                    bus_write_q <= state_q inside {PUSH_H, PUSH_L};
                    bus_addr_q  <= xfer_addr_d;
                    bus_wdata_q <= xfer_wdata_d;
                end else if (ifc_io.BusDone) begin
                    bus_req_q   <= 1'b0;
                    bus_write_q <= 1'b0;
                    bus_addr_q  <= 16'h0000;
                    bus_wdata_q <= 8'h00;
                    case (state_q)
                        PUSH_H: state_q <= PUSH_L;
                        PUSH_L: begin
                            sp_load_q <= 1'b1;
                            sp_new_q  <= sp_q - 16'd2;
                            state_q   <= im_q == 2'd2 ? RD_L : LOAD;
                            pc_load_q <= im_q != 2'd2;
                            pc_new_q  <= im_q == 2'd2 ? pc_new_q : vec_pc_d;
                        end
                        RD_L: begin
                            pc_new_q[7:0] <= ifc_io.BusRData;
                            state_q       <= RD_H;
                        end
                        RD_H: begin
                            pc_new_q[15:8] <= ifc_io.BusRData;
                            pc_load_q      <= 1'b1;
                            state_q        <= LOAD;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end
endmodule
